ram_credit_reader: RTL
======================

# ram_credit_reader

Read initiator for the 256x16 RAM read port. It accepts a burst command (start address and length) and issues one `rd_read` per cycle, bounded by credits. Returned `rd_data`/`rd_valid` words go into a small FIFO and leave as a valid/ready stream with a last-beat flag. Credits equal free FIFO slots minus outstanding reads, so the FIFO never overflows and the RAM needs no back-pressure.

## Interface
- `DEPTH`, 4: response FIFO depth and credit pool; power of 2, range 2..16. Needs ≥4 for full throughput.
- `AW`, 8: RAM address width.
- `DW`, 16: RAM data width.
- Ports:
  - `clk` in 1: clock, rising edge.
  - `rstp` in 1: reset, asynchronous, active-high.
  - `cmd_addr` in AW: burst start address.
  - `cmd_len` in 9: burst length in words, 0..256.
  - `cmd_valid` in 1: command request.
  - `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
  - `rd_addr` out AW: RAM read address.
  - `rd_read` out 1: RAM read strobe, one word per cycle high.
  - `rd_data` in DW: RAM read data.
  - `rd_valid` in 1: RAM read data valid.
  - `out_data` out DW: stream data.
  - `out_valid` out 1: stream valid.
  - `out_ready` in 1: stream ready.
  - `out_last` out 1: final beat of burst, qualified by `out_valid`.
  - `busy` out 1: burst in progress.
  - `err` out 1: sticky; a `rd_valid` arrived with no outstanding read.

## Operation
- Reset values: `cmd_ready`, `rd_read`, `out_valid`, `out_last`, `busy` and `err` are 0. `rd_addr` and `out_data` are 0. Credits = DEPTH, outstanding = 0, FIFO empty, state IDLE. `cmd_ready` rises in the first cycle after `rstp` deasserts.
- FSM states:
  - IDLE: `cmd_ready`=1, `busy`=0. On accept with `cmd_len`≠0, latch `cmd_addr` into the address counter, load remaining = `cmd_len`, go to RUN. On accept with `cmd_len`=0, stay in IDLE; no read, no beat.
  - RUN: `busy`=1, `cmd_ready`=0. Drive `rd_read`=1 and `rd_addr`=address counter (registered outputs) when credits>0 and remaining>0. Each issue decrements credits and remaining, increments the address counter and increments outstanding. When the last read is issued, go to DRAIN.
  - DRAIN: `rd_read`=0. Go to IDLE on the cycle the last beat handshakes (`out_valid & out_ready & out_last`).
- Address counter wraps 0xFF→0x00 (mod 2^AW) with no error.
- Credits: −1 on issue, +1 on output handshake; both in the same cycle leaves credits unchanged. Credits never exceed DEPTH and never go below 0.
- Outstanding: +1 on issue, −1 on `rd_valid`; both in the same cycle leaves it unchanged. `rd_valid` with outstanding=0 is dropped, not written to the FIFO, and sets `err`. Only reset clears `err`.
- Response FIFO:
  - Written on accepted `rd_valid`.
  - Show-ahead read: `out_data` is the head word, `out_valid` = FIFO non-empty.
  - Simultaneous write and read on a full or empty FIFO is legal.
- `out_last` is high when the head word is the final word of the burst, tracked by a beat counter loaded from `cmd_len`.
- Stream rule: while `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable.
- Reset mid-burst: abort immediately. FIFO flushed, counters reinitialised, state IDLE. Late RAM responses after reset set `err`.

## Timing
- Command accepted in cycle T: first `rd_read` is high in cycle T+1.
- RAM latency: `rd_read` in cycle C gives `rd_valid` in cycle C+2.
- FIFO write at the end of cycle C+2: `out_valid` in cycle C+3.
- Command to first beat: 4 cycles.
- Credit loop is 4 cycles (issue → beat consumed → credit usable). With DEPTH≥4 and `out_ready`=1, the burst streams at 1 word/cycle. With DEPTH=2, the peak rate is 1 word per 2 cycles.
- An N-word burst with `out_ready`=1 and DEPTH=4 ends with the last beat in cycle T+N+3. `cmd_ready` returns in cycle T+N+4.
- Back-to-back bursts are separated by the full drain; bursts never overlap.

## Test plan
- Reset, then RAM preloaded mem[i]=i, cmd addr=0x10, len=4, `out_ready`=1 → `rd_read` in cycles T+1..T+4. Beats 0x10..0x13 in cycles T+4..T+7. `out_last` only on 0x13. `cmd_ready`=1 in T+8.
- Wrap: addr=0xFE, len=4 → `rd_addr` sequence FE,FF,00,01. Data matches mem. `err`=0.
- Back-pressure: len=16, `out_ready`=0 → exactly DEPTH reads issued, then `rd_read` stays 0. Release `out_ready` → remaining 12 words arrive in order, no loss or duplicate.
- Random `out_ready` (50%) with len=256 → 256 ordered words, exactly one `out_last`. Credits return to DEPTH and the FSM ends in IDLE.
- len=0 command → accepted in one cycle, no `rd_read`, no `out_valid`, `busy` stays 0.
- `rstp` pulsed mid-burst with 2 reads in flight → outputs 0 immediately. The following stray `rd_valid` sets `err`=1. A new len=2 command then completes correctly.

Source files
------------

// File: rtl/ram_credit_reader.sv
// rtl/ram_credit_reader.sv - credit-bounded burst reader for a fixed-latency RAM read port
module ram_credit_reader #(
    parameter int DEPTH = 4,
    parameter int AW    = 8,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rstp,
    input  logic [AW-1:0] cmd_addr,
    input  logic [8:0]    cmd_len,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    output logic [AW-1:0] rd_addr,
    output logic          rd_read,
    input  logic [DW-1:0] rd_data,
    input  logic          rd_valid,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state;
    logic [AW-1:0] addr_cnt;
    logic [8:0]    remaining;
    logic [8:0]    beats_left;
    logic [CW-1:0] credits;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] count;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [DW-1:0] mem [DEPTH];

    logic          accept;
    logic          issue;
    logic          rv_acc;
    logic          out_fire;
    logic [AW-1:0] issue_addr;

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rptr] : '0;
    assign out_last  = out_valid && (beats_left == 9'd1);
    assign out_fire  = out_valid & out_ready;

    // Issue decision: a credit returned by this cycle's beat handshake is usable
    // immediately, which closes the credit loop in 4 cycles.
    always_comb begin
        accept     = cmd_valid & cmd_ready;
        issue_addr = accept ? cmd_addr : addr_cnt;
        issue      = (accept && (cmd_len != 9'd0)) ||
                     ((state == RUN) && (remaining != 9'd0) && ((credits != '0) || out_fire));
        rv_acc     = rd_valid && (outstanding != '0);
    end

    // Burst FSM with registered handshake, strobe and status outputs.
    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            rd_read   <= 1'b0;
            rd_addr   <= '0;
            addr_cnt  <= '0;
            remaining <= 9'd0;
        end else begin
            rd_read <= issue;
            if (issue) begin
                rd_addr  <= issue_addr;
                addr_cnt <= issue_addr + AW'(1);
            end
            case (state)
                IDLE: begin
                    if (accept && (cmd_len != 9'd0)) begin
                        remaining <= cmd_len - 9'd1;
                        state     <= (cmd_len == 9'd1) ? DRAIN : RUN;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                    end else begin
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                RUN: begin
                    if (issue) begin
                        remaining <= remaining - 9'd1;
                        if (remaining == 9'd1) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_fire && out_last) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Beat counter marks the final word of the burst at the stream head.
    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            beats_left <= 9'd0;
        end else if (accept && (cmd_len != 9'd0)) begin
            beats_left <= cmd_len;
        end else if (out_fire) begin
            beats_left <= beats_left - 9'd1;
        end
    end

    // Credit pool, outstanding-read tracking, sticky error and FIFO pointers.
    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            credits     <= CW'(DEPTH);
            outstanding <= '0;
            count       <= '0;
            wptr        <= '0;
            rptr        <= '0;
            err         <= 1'b0;
        end else begin
            credits     <= credits - CW'(issue) + CW'(out_fire);
            outstanding <= outstanding + CW'(issue) - CW'(rv_acc);
            count       <= count + CW'(rv_acc) - CW'(out_fire);
            if (rd_valid && (outstanding == '0)) begin
                err <= 1'b1;
            end
            if (rv_acc) begin
                wptr <= wptr + PW'(1);
            end
            if (out_fire) begin
                rptr <= rptr + PW'(1);
            end
        end
    end

    // Response storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (rv_acc) begin
            mem[wptr] <= rd_data;
        end
    end

endmodule
